// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst command to single-word memory transaction sequencer
//
// Accepts one burst command (start address, length-1, direction) and turns it
// into one valid/ready transaction per word on the memory port. Write words come
// from the wdata stream; read words leave on the rdata stream with backpressure.
// A per-word timeout abandons the burst if the memory never answers.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o      burst command handshake (cmd_write_i, cmd_addr_i, cmd_len_i)
//   wdata_valid_i/wdata_ready_o  write stream in (wdata_i)
//   rdata_valid_o/rdata_ready_i  read stream out (rdata_o)
//   done_o                       one-cycle pulse when a burst ends (normally or by timeout)
//   err_o                        sticky timeout flag, cleared on the next command accept
//   mem_*                        single-word memory port
module mem_burst_ctrl #(
  parameter int WIDTH = 32,
  parameter int ADDRE = 8,
  parameter int LENW  = 8,
  parameter int TMO   = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [ADDRE-1:0] cmd_addr_i,
  input  logic [LENW-1:0]  cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             rdata_valid_o,
  input  logic             rdata_ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_valid_o,
  output logic             mem_wrdata_o,
  output logic [ADDRE-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFETCH,
    S_ISSUE,
    S_WAIT,
    S_RHOLD
  } state_t;

  state_t state_q, state_d;

  logic [ADDRE-1:0] addr_q;
  logic [LENW-1:0]  rem_q;
  logic             dir_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             err_q;
  logic             done_q;
  logic [3:0]       tmo_q;

  logic accept, take_wdata, rd_capture, advance, tmo_hit, tmo_inc, done_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    take_wdata    = 1'b0;
    rd_capture    = 1'b0;
    advance       = 1'b0;
    tmo_hit       = 1'b0;
    tmo_inc       = 1'b0;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    mem_valid_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = cmd_write_i ? S_WFETCH : S_ISSUE;
        end
      end
      S_WFETCH: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          take_wdata = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Only ever one cycle long, so mem_valid_o can never be high twice in a row.
        mem_valid_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          if (dir_q) begin
            advance = 1'b1;
          end else begin
            rd_capture = 1'b1;
            state_d    = S_RHOLD;
          end
        end else if (tmo_q == 4'(TMO - 1)) begin
          // This is the TMO-th cycle spent waiting: abandon the burst.
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_RHOLD: begin
        if (rdata_ready_i) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (rem_q == '0) state_d = S_IDLE;
      else             state_d = dir_q ? S_WFETCH : S_ISSUE;
    end
  end

  assign done_d = tmo_hit | (advance && (rem_q == '0));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q   <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        addr_q <= cmd_addr_i;
        rem_q  <= cmd_len_i;
        dir_q  <= cmd_write_i;
        err_q  <= 1'b0;
      end
      if (take_wdata) wdata_q <= wdata_i;
      if (state_q == S_ISSUE) tmo_q <= '0;
      else if (tmo_inc)       tmo_q <= tmo_q + 4'd1;
      if (tmo_hit) err_q <= 1'b1;
      if (rd_capture) begin
        rdata_q  <= mem_rdata_i;
        rvalid_q <= 1'b1;
      end else if (state_q == S_RHOLD && rdata_ready_i) begin
        rvalid_q <= 1'b0;
      end
      // Address wraps naturally at 2^ADDRE.
      if (advance && (rem_q != '0)) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_wrdata_o  = dir_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign err_o         = err_q;
  assign done_o        = done_q;

endmodule
